// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch, data and SRAM signal bundle for mem_arbiter
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int MEM_AW = 10
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [31:0]       i_rdata;

    logic              d_req;
    logic [1:0]        d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              d_err;

    logic              m_en;
    logic [3:0]        m_we;
    logic [MEM_AW-1:0] m_addr;
    logic [31:0]       m_wdata;
    logic [31:0]       m_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err,
               m_en, m_we, m_addr, m_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err,
               m_en, m_we, m_addr, m_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port SRAM arbiter, data priority with fetch anti-starvation
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int MEM_AW     = 10,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {RESP_IDLE, RESP_FETCH, RESP_DATA} resp_t;

    resp_t      resp_src, resp_nxt;
    logic [3:0] starve_cnt, starve_nxt;
    logic       err_q, err_nxt;
    logic       ld_q, ld_nxt;

    logic       force_i, i_win, d_win, mis;
    logic [1:0] off;

    always_ff @(posedge clk) begin
        if (!rst) begin
            resp_src   <= RESP_IDLE;
            starve_cnt <= 4'd0;
            err_q      <= 1'b0;
            ld_q       <= 1'b0;
        end else begin
            resp_src   <= resp_nxt;
            starve_cnt <= starve_nxt;
            err_q      <= err_nxt;
            ld_q       <= ld_nxt;
        end
    end

    always_comb begin
        force_i = (starve_cnt == 4'(STARVE_MAX)) && bus.i_req;
        i_win   = rst && bus.i_req && (force_i || !bus.d_req);
        d_win   = rst && bus.d_req && !i_win;
        off     = bus.d_addr[1:0];
        // loads are word accesses, so they share the word alignment rule
        mis     = ((bus.d_we == 2'b10) && off[0]) ||
                  ((bus.d_we == 2'b11 || bus.d_we == 2'b00) && (off != 2'b00));

        bus.i_gnt   = i_win;
        bus.d_gnt   = d_win;
        bus.m_en    = 1'b0;
        bus.m_we    = 4'h0;
        bus.m_addr  = '0;
        bus.m_wdata = 32'h0;

        if (i_win) begin
            bus.m_en   = 1'b1;
            bus.m_addr = bus.i_addr[MEM_AW+1:2];
        end else if (d_win) begin
            bus.m_addr = bus.d_addr[MEM_AW+1:2];
            if (!mis) begin
                bus.m_en = 1'b1;
                case (bus.d_we)
                    2'b01: begin
                        bus.m_we    = 4'b0001 << off;
                        bus.m_wdata = {4{bus.d_wdata[7:0]}};
                    end
                    2'b10: begin
                        bus.m_we    = 4'b0011 << off;
                        bus.m_wdata = {2{bus.d_wdata[15:0]}};
                    end
                    2'b11: begin
                        bus.m_we    = 4'hF;
                        bus.m_wdata = bus.d_wdata;
                    end
                    default: begin
                        bus.m_we    = 4'h0;
                        bus.m_wdata = 32'h0;
                    end
                endcase
            end
        end

        resp_nxt = RESP_IDLE;
        if (i_win)      resp_nxt = RESP_FETCH;
        else if (d_win) resp_nxt = RESP_DATA;
        err_nxt = d_win && mis;
        ld_nxt  = d_win && (bus.d_we == 2'b00);

        starve_nxt = starve_cnt;
        if (!bus.i_req || i_win)
            starve_nxt = 4'd0;
        else if (starve_cnt != 4'(STARVE_MAX))
            starve_nxt = starve_cnt + 4'd1;
    end

    // response side is also held quiet during reset so a pending access is dropped
    always_comb begin
        bus.i_rvalid = rst && (resp_src == RESP_FETCH);
        bus.i_rdata  = bus.i_rvalid ? bus.m_rdata : 32'h0;
        bus.d_rvalid = rst && (resp_src == RESP_DATA);
        bus.d_err    = bus.d_rvalid && err_q;
        bus.d_rdata  = (bus.d_rvalid && ld_q && !err_q) ? bus.m_rdata : 32'h0;
    end
endmodule
